// File: rtl/ram256x1s_march_bist.sv
// March C- self-test controller and access mux for a RAM256X1S-style 1-bit distributed RAM.
// Idle: user port passes straight through; RUN: BIST owns WE/A/D and checks the async O output.
module ram256x1s_march_bist #(
  parameter int ADDR_BITS    = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [ADDR_BITS-1:0] FAIL_ADDR,
  output logic [2:0]           FAIL_ELEM,
  input  logic                 USR_WE,
  input  logic [ADDR_BITS-1:0] USR_A,
  input  logic                 USR_D,
  output logic                 USR_O,
  output logic                 RAM_WE,
  output logic [ADDR_BITS-1:0] RAM_A,
  output logic                 RAM_D,
  input  logic                 RAM_O
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};

  logic [1:0]           r_state;
  logic [2:0]           r_elem;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_phase;     // 0 = read slot, 1 = write slot of a two-op element
  logic                 r_done;
  logic                 r_fail;
  logic [ADDR_BITS-1:0] r_fail_addr;
  logic [2:0]           r_fail_elem;

  logic w_busy;
  logic w_single_op;
  logic w_is_read;
  logic w_is_write;
  logic w_exp_bit;
  logic w_wr_bit;
  logic w_down;
  logic w_next_down;
  logic w_last_addr;
  logic w_slot_end;
  logic w_elem_end;
  logic w_miscmp;

  // Element decode: M0 write-only, M5 read-only, M1..M4 read then write.
  assign w_busy      = (r_state == S_RUN);
  assign w_single_op = (r_elem == 3'd0) || (r_elem == 3'd5);
  assign w_is_read   = (r_elem != 3'd0) && ((r_elem == 3'd5) || !r_phase);
  assign w_is_write  = (r_elem == 3'd0) || ((r_elem != 3'd5) && r_phase);
  assign w_exp_bit   = (r_elem == 3'd2) || (r_elem == 3'd4);
  assign w_wr_bit    = (r_elem == 3'd1) || (r_elem == 3'd3);
  assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
  assign w_next_down = (r_elem == 3'd2) || (r_elem == 3'd3);
  assign w_last_addr = w_down ? (r_addr == '0) : (r_addr == ADDR_MAX);
  assign w_slot_end  = w_single_op || r_phase;
  assign w_elem_end  = w_slot_end && w_last_addr;
  assign w_miscmp    = w_busy && w_is_read && (RAM_O != w_exp_bit);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_elem      <= 3'd0;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (START) begin
            r_state     <= S_RUN;
            r_elem      <= 3'd0;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
          end
        end
        S_RUN: begin
          if (w_miscmp) begin
            r_fail <= 1'b1;
            if (!r_fail) begin
              r_fail_addr <= r_addr;
              r_fail_elem <= r_elem;
            end
          end
          if (w_miscmp && STOP_ON_FAIL) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_phase <= 1'b0;
          end else if (w_elem_end && (r_elem == 3'd5)) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_phase <= 1'b0;
          end else if (w_elem_end) begin
            // Reload for the next element's direction: M3/M4 descend.
            r_elem  <= r_elem + 3'd1;
            r_addr  <= w_next_down ? ADDR_MAX : '0;
            r_phase <= 1'b0;
          end else if (w_slot_end) begin
            r_addr  <= w_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
            r_phase <= 1'b0;
          end else begin
            r_phase <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = w_busy;
  assign DONE      = r_done;
  assign FAIL      = r_fail;
  assign FAIL_ADDR = r_fail_addr;
  assign FAIL_ELEM = r_fail_elem;

  assign RAM_WE = w_busy ? w_is_write : USR_WE;
  assign RAM_A  = w_busy ? r_addr     : USR_A;
  assign RAM_D  = w_busy ? w_wr_bit   : USR_D;
  assign USR_O  = w_busy ? 1'b0       : RAM_O;

endmodule

// File: tb/tb_ram256x1s_march_bist.sv
// Bench: two BIST instances (STOP_ON_FAIL 0 and 1), each driving a behavioural 256x1 RAM
// with optional stuck-at injection, checked against a march-level reference model.
module tb_ram256x1s_march_bist;
  localparam int AW = 8;
  localparam int N  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n  [2];
  logic          start  [2];
  logic          usr_we [2];
  logic [AW-1:0] usr_a  [2];
  logic          usr_d  [2];
  wire           busy   [2];
  wire           done   [2];
  wire           fail   [2];
  wire  [AW-1:0] fail_addr [2];
  wire  [2:0]    fail_elem [2];
  wire           usr_o  [2];
  wire           ram_we [2];
  wire  [AW-1:0] ram_a  [2];
  wire           ram_d  [2];
  wire           ram_o  [2];

  logic          f_en   [2];
  logic [AW-1:0] f_addr [2];
  logic          f_val  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bist
    logic mem [N];

    ram256x1s_march_bist #(.ADDR_BITS(AW), .STOP_ON_FAIL(gi == 1)) u_dut (
      .CLK(clk), .RST_N(rst_n[gi]), .START(start[gi]),
      .BUSY(busy[gi]), .DONE(done[gi]), .FAIL(fail[gi]),
      .FAIL_ADDR(fail_addr[gi]), .FAIL_ELEM(fail_elem[gi]),
      .USR_WE(usr_we[gi]), .USR_A(usr_a[gi]), .USR_D(usr_d[gi]), .USR_O(usr_o[gi]),
      .RAM_WE(ram_we[gi]), .RAM_A(ram_a[gi]), .RAM_D(ram_d[gi]), .RAM_O(ram_o[gi])
    );

    always_ff @(posedge clk) begin
      if (ram_we[gi]) mem[ram_a[gi]] <= ram_d[gi];
    end

    assign ram_o[gi] = (f_en[gi] && (ram_a[gi] == f_addr[gi])) ? f_val[gi] : mem[ram_a[gi]];
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit ref_mem [2][N];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected BIST drive in busy cycle k of a fault-free run, from element lengths N,2N,2N,2N,2N,N.
  function automatic int exp_we(input int k);
    if (k < N) return 1;
    if (k < 9*N) return (k - N) % 2;
    return 0;
  endfunction

  function automatic int exp_a(input int k);
    int j, e, i;
    if (k < N) return k;
    if (k >= 9*N) return k - 9*N;
    j = (k - N) / 2;
    e = 1 + j / N;
    i = j % N;
    return (e >= 3) ? (N - 1 - i) : i;
  endfunction

  function automatic int exp_d(input int k);
    int e;
    if (k < N) return 0;
    e = 1 + ((k - N) / 2) / N;
    return (e == 1 || e == 3) ? 1 : 0;
  endfunction

  // March C- applied to the reference memory: returns busy cycles and first-fail info.
  task automatic march_model(input int idx, output int cyc, output int e_fail,
                             output int e_addr, output int e_elem);
    int  rd_exp [6] = '{-1, 0, 1, 0, 1, 0};
    int  wr_val [6] = '{ 0, 1, 0, 1, 0, -1};
    bit  down   [6] = '{0, 0, 0, 1, 1, 0};
    cyc = 0; e_fail = 0; e_addr = 0; e_elem = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        int seen;
        a = down[e] ? (N - 1 - i) : i;
        if (rd_exp[e] >= 0) begin
          seen = (f_en[idx] && a == int'(f_addr[idx])) ? int'(f_val[idx]) : int'(ref_mem[idx][a]);
          cyc++;
          if (seen != rd_exp[e]) begin
            if (e_fail == 0) begin
              e_addr = a;
              e_elem = e;
            end
            e_fail = 1;
            if (idx == 1) return;
          end
        end
        if (wr_val[e] >= 0) begin
          cyc++;
          ref_mem[idx][a] = (wr_val[e] == 1);
        end
      end
    end
  endtask

  task automatic usr_write(input int idx, input int a, input bit d);
    @(negedge clk);
    usr_we[idx] = 1'b1;
    usr_a[idx]  = a[AW-1:0];
    usr_d[idx]  = d;
    @(negedge clk);
    usr_we[idx] = 1'b0;
    ref_mem[idx][a] = d;
  endtask

  task automatic usr_read(input int idx, input int a, output int v);
    @(negedge clk);
    usr_we[idx] = 1'b0;
    usr_a[idx]  = a[AW-1:0];
    #1 v = int'(usr_o[idx]);
  endtask

  task automatic load(input int idx, input bit random_fill);
    for (int a = 0; a < N; a++) usr_write(idx, a, random_fill ? 1'($urandom) : 1'b1);
  endtask

  task automatic readback(input int idx);
    int v, e;
    for (int a = 0; a < N; a++) begin
      usr_read(idx, a, v);
      e = (f_en[idx] && a == int'(f_addr[idx])) ? int'(f_val[idx]) : int'(ref_mem[idx][a]);
      check($sformatf("readback%0d[%0d]", idx, a), v, e);
    end
  endtask

  // Pulse START and count busy cycles; optional re-START at cycle 100, USR_WE held high,
  // per-cycle drive checks, and asynchronous reset at cycle abort_at.
  task automatic run_bist(input int idx, input bit restart, input bit watch,
                          input int abort_at, output int cyc);
    @(negedge clk);
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx]  = 1'b0;
    usr_we[idx] = watch;
    check("busy_on",   int'(busy[idx]), 1);
    check("done_clr",  int'(done[idx]), 0);
    check("fail_clr",  int'(fail[idx]), 0);
    check("faddr_clr", int'(fail_addr[idx]), 0);
    check("felem_clr", int'(fail_elem[idx]), 0);
    cyc = 0;
    while (busy[idx] && cyc < 3000) begin
      if (watch) begin
        check($sformatf("bist_we@%0d", cyc), int'(ram_we[idx]), exp_we(cyc));
        check($sformatf("bist_a@%0d", cyc),  int'(ram_a[idx]),  exp_a(cyc));
        if (exp_we(cyc) == 1) check($sformatf("bist_d@%0d", cyc), int'(ram_d[idx]), exp_d(cyc));
        check($sformatf("usr_o_busy@%0d", cyc), int'(usr_o[idx]), 0);
      end
      if (cyc == abort_at) begin
        #2 rst_n[idx] = 1'b0;
        #1;
        check("abort_busy", int'(busy[idx]), 0);
        check("abort_done", int'(done[idx]), 0);
        check("abort_fail", int'(fail[idx]), 0);
        usr_we[idx] = 1'b0;
        @(negedge clk);
        rst_n[idx] = 1'b1;
        return;
      end
      start[idx] = restart && (cyc == 100);
      cyc++;
      @(negedge clk);
    end
    start[idx]  = 1'b0;
    usr_we[idx] = 1'b0;
  endtask

  task automatic run_and_compare(input int idx, input bit restart, input bit watch);
    int cyc, e_cyc, e_fail, e_addr, e_elem;
    march_model(idx, e_cyc, e_fail, e_addr, e_elem);
    run_bist(idx, restart, watch, -1, cyc);
    check("cycles", cyc, e_cyc);
    check("busy_off", int'(busy[idx]), 0);
    check("done", int'(done[idx]), 1);
    check("fail", int'(fail[idx]), e_fail);
    check("fail_addr", int'(fail_addr[idx]), e_addr);
    check("fail_elem", int'(fail_elem[idx]), e_elem);
    readback(idx);
  endtask

  int v, cyc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; usr_we[i] = 1'b0; usr_a[i] = '0; usr_d[i] = 1'b0;
      f_en[i] = 1'b0; f_addr[i] = '0; f_val[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", int'(busy[i]), 0);
      check("rst_done", int'(done[i]), 0);
      check("rst_fail", int'(fail[i]), 0);
      check("rst_faddr", int'(fail_addr[i]), 0);
      check("rst_felem", int'(fail_elem[i]), 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Idle passthrough
    usr_write(0, 'h33, 1'b1);
    usr_read(0, 'h33, v);
    check("pass_rd33", v, 1);
    check("pass_ram_a", int'(ram_a[0]), 'h33);
    check("pass_ram_we", int'(ram_we[0]), 0);
    for (int t = 0; t < 12; t++) begin
      int a;
      bit d;
      a = int'($urandom_range(N - 1, 0));
      d = 1'($urandom);
      usr_write(0, a, d);
      usr_read(0, a, v);
      check("pass_rand", v, int'(d));
    end

    // Fault-free all-ones INIT, re-START at cycle 100, USR_WE held high during BUSY
    load(0, 1'b0);
    run_and_compare(0, 1'b1, 1'b1);
    check("ff_cycles_fixed", cyc_of_last(), 2560);

    // Stuck-at-1 at 0x5A with STOP_ON_FAIL=1
    f_en[1] = 1'b1; f_addr[1] = 8'h5A; f_val[1] = 1'b1;
    load(1, 1'b1);
    run_bist(1, 1'b0, 1'b0, -1, cyc);
    check("sa1_stop_cycles", cyc, 437);
    check("sa1_stop_done", int'(done[1]), 1);
    check("sa1_stop_fail", int'(fail[1]), 1);
    check("sa1_stop_addr", int'(fail_addr[1]), 'h5A);
    check("sa1_stop_elem", int'(fail_elem[1]), 1);

    // Same fault, STOP_ON_FAIL=0: first failure not overwritten by later ones
    f_en[0] = 1'b1; f_addr[0] = 8'h5A; f_val[0] = 1'b1;
    run_bist(0, 1'b0, 1'b0, -1, cyc);
    check("sa1_run_cycles", cyc, 2560);
    check("sa1_run_done", int'(done[0]), 1);
    check("sa1_run_fail", int'(fail[0]), 1);
    check("sa1_run_addr", int'(fail_addr[0]), 'h5A);
    check("sa1_run_elem", int'(fail_elem[0]), 1);

    // Asynchronous reset at busy cycle 1000, then a clean full pass
    f_en[0] = 1'b0;
    run_bist(0, 1'b0, 1'b0, 1000, cyc);
    run_and_compare(0, 1'b0, 1'b0);

    // Randomised faults on both instances
    for (int t = 0; t < 6; t++) begin
      int idx;
      idx = int'($urandom_range(1, 0));
      f_en[idx]   = 1'($urandom);
      f_addr[idx] = 8'($urandom);
      f_val[idx]  = 1'($urandom);
      load(idx, 1'b1);
      run_and_compare(idx, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Busy-cycle length of the most recent run on instance 0, measured independently from BUSY.
  int busy_len0 = 0;
  int busy_cnt0 = 0;
  always @(negedge clk) begin
    if (busy[0]) busy_cnt0 <= busy_cnt0 + 1;
    else if (busy_cnt0 != 0) begin
      busy_len0 <= busy_cnt0;
      busy_cnt0 <= 0;
    end
  end

  function automatic int cyc_of_last();
    return busy_len0;
  endfunction

endmodule
